// File: rtl/evs_pkg.sv
// Shared definitions for the exhaustive vector sequencer: FSM states, default
// MISR constants and the MISR step used by both the design and its checker.
package evs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } evs_state_t;

    localparam int unsigned MISR_MAX_W   = 32;
    localparam logic [15:0] EVS_DEF_POLY = 16'h1021;
    localparam logic [15:0] EVS_DEF_SEED = 16'h0000;

    // One MISR clock: shift left, fold in POLY when the MSB falls off, xor in
    // the response. Operands are right-aligned in MISR_MAX_W bits.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] resp,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic                  fb;
        mask = (width >= MISR_MAX_W) ? '1
                                     : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
        fb   = sig[5'(width - 1)];
        nxt  = (sig << 1) ^ (fb ? poly : '0) ^ resp;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: loads SEED on request, otherwise
// compacts one response word per step enable.
module misr_reg
    import evs_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(EVS_DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(EVS_DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [SIG_W-1:0] resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0]      sig_q;
    logic [SIG_W-1:0]      sig_step;
    logic [MISR_MAX_W-1:0] sig_w;
    logic [MISR_MAX_W-1:0] resp_w;
    logic [MISR_MAX_W-1:0] poly_w;

    always_comb begin
        sig_w                = '0;
        resp_w               = '0;
        poly_w               = '0;
        sig_w[SIG_W-1:0]     = sig_q;
        resp_w[SIG_W-1:0]    = resp;
        poly_w[SIG_W-1:0]    = POLY;
        sig_step             = SIG_W'(misr_step(sig_w, resp_w, poly_w, SIG_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else if (load) begin
            sig_q <= SEED;
        end else if (step) begin
            sig_q <= sig_step;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps every input vector of a combinational netlist, waits SETTLE cycles
// per vector, compacts the responses into a MISR and compares the signature.
module exhaustive_vector_sequencer
    import evs_pkg::*;
#(
    parameter int unsigned      N_IN   = 3,
    parameter int unsigned      N_OUT  = 4,
    parameter int unsigned      SIG_W  = 16,
    parameter int unsigned      SETTLE = 0,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(EVS_DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(EVS_DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] expected_sig,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig
);

    evs_state_t       state;
    evs_state_t       state_nxt;
    logic [N_IN-1:0]  vec_q;
    logic [7:0]       cnt_q;
    logic             pass_q;
    logic [SIG_W-1:0] sig_w;
    logic [SIG_W-1:0] resp_ext;

    logic sweep_load;
    logic misr_step_en;
    logic vec_inc;
    logic cnt_load;
    logic cnt_dec;
    logic pass_upd;
    logic last_vec;

    assign last_vec = &vec_q;
    assign resp_ext = SIG_W'(resp_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sweep_load   = 1'b0;
        misr_step_en = 1'b0;
        vec_inc      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        pass_upd     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sweep_load = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                misr_step_en = 1'b1;
                if (last_vec) begin
                    state_nxt = DONE;
                end else begin
                    vec_inc   = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                pass_upd = 1'b1;
                // A start held through DONE relaunches directly, keeping busy
                // high across back-to-back sweeps; pass still gets this result.
                if (start) begin
                    sweep_load = 1'b1;
                    state_nxt  = WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            if (sweep_load) begin
                vec_q <= '0;
            end else if (vec_inc) begin
                vec_q <= vec_q + 1'b1;
            end

            if (sweep_load || cnt_load) begin
                cnt_q <= 8'(SETTLE);
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (pass_upd) begin
                pass_q <= (sig_w == expected_sig);
            end else if (sweep_load) begin
                pass_q <= 1'b0;
            end
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sweep_load),
        .step  (misr_step_en),
        .resp  (resp_ext),
        .sig   (sig_w)
    );

    assign vec_out = vec_q;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign pass    = pass_q;
    assign sig     = sig_w;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Scoreboard bench for exhaustive_vector_sequencer with SETTLE=0 and SETTLE=3
// instances driven by a small stand-in netlist selected per sweep.
module tb_exhaustive_vector_sequencer;
    import evs_pkg::*;

    localparam logic [15:0] POLY_V = 16'h1021;
    localparam logic [15:0] SEED_V = 16'h0000;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start3;
    logic [15:0] exp0, exp3;
    logic [2:0]  vec0, vec3;
    logic [3:0]  resp0, resp3;
    logic        busy0, busy3, done0, done3, pass0, pass3;
    logic [15:0] sig0, sig3;
    int unsigned mode0 = 0, mode3 = 0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0, n_ok = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in netlists: 3 = original, 4 = balanced equivalent, 5 = f1 inverted.
    function automatic logic [3:0] net_resp(input int unsigned m, input logic [2:0] v);
        logic x0, x1, x2;
        {x2, x1, x0} = v;
        case (m)
            1: return (v == 3'd0) ? 4'b0001 : 4'b0000;
            2: return (v == 3'd7) ? 4'b0001 : 4'b0000;
            3: return {~(x0 ^ x1 ^ x2), x0 | x2, x1 & x2, x0 ^ x1};
            4: return {(x0 ~^ x1) ^ x2, ~(~x0 & ~x2), ~(~x1 | ~x2), (x0 & ~x1) | (~x0 & x1)};
            5: return {~(x0 ^ x1 ^ x2), x0 | x2, x1 & x2, ~(x0 ^ x1)};
            default: return 4'b0000;
        endcase
    endfunction

    always_comb resp0 = net_resp(mode0, vec0);
    always_comb resp3 = net_resp(mode3, vec3);

    exhaustive_vector_sequencer #(
        .N_IN(3), .N_OUT(4), .SIG_W(16), .SETTLE(0), .POLY(POLY_V), .SEED(SEED_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected_sig(exp0),
        .vec_out(vec0), .resp_in(resp0), .busy(busy0), .done(done0),
        .pass(pass0), .sig(sig0)
    );

    exhaustive_vector_sequencer #(
        .N_IN(3), .N_OUT(4), .SIG_W(16), .SETTLE(3), .POLY(POLY_V), .SEED(SEED_V)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected_sig(exp3),
        .vec_out(vec3), .resp_in(resp3), .busy(busy3), .done(done3),
        .pass(pass3), .sig(sig3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_ok++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [15:0] model_sig(input int unsigned m);
        logic [MISR_MAX_W-1:0] s;
        s = 32'(SEED_V);
        for (int unsigned v = 0; v < 8; v++)
            s = misr_step(s, 32'(net_resp(m, 3'(v))), 32'(POLY_V), 16);
        return 16'(s);
    endfunction

    function automatic logic [31:0] get_vec(input int unsigned w);
        return (w == 0) ? 32'(vec0) : 32'(vec3);
    endfunction
    function automatic logic [31:0] get_sig(input int unsigned w);
        return (w == 0) ? 32'(sig0) : 32'(sig3);
    endfunction
    function automatic logic [31:0] get_busy(input int unsigned w);
        return (w == 0) ? 32'(busy0) : 32'(busy3);
    endfunction
    function automatic logic [31:0] get_pass(input int unsigned w);
        return (w == 0) ? 32'(pass0) : 32'(pass3);
    endfunction
    function automatic logic get_done(input int unsigned w);
        return (w == 0) ? done0 : done3;
    endfunction

    task automatic set_start(input int unsigned w, input logic val);
        if (w == 0) start0 = val; else start3 = val;
    endtask
    task automatic set_exp(input int unsigned w, input logic [15:0] val);
        if (w == 0) exp0 = val; else exp3 = val;
    endtask
    task automatic set_mode(input int unsigned w, input int unsigned m);
        if (w == 0) mode0 = m; else mode3 = m;
    endtask

    task automatic wait_done0(output int unsigned at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (done0) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    // One full sweep: expected_sig is wrong until mid-sweep so only its DONE
    // value can matter; optional pokes of start while busy must be ignored.
    task automatic sweep(input int unsigned w, input int unsigned m,
                         input logic [15:0] exp_in, input bit chk_vec, input bit poke);
        exp_t        e, got;
        int unsigned s, t0, el, dones;
        bit          seen;
        s      = (w == 0) ? 0 : 3;
        e.sig  = model_sig(m);
        e.pass = (e.sig == exp_in);
        e.lat  = 8 * (s + 2);
        sb.push_back(e);

        @(negedge clk);
        set_mode(w, m);
        set_exp(w, ~exp_in);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        t0 = cyc;
        set_start(w, 1'b0);
        check("busy_on_start", get_busy(w), 1);
        check("pass_cleared", get_pass(w), 0);

        seen = 1'b0;
        el   = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            el = cyc - t0;
            if (el == 10) set_exp(w, exp_in);
            if (poke) set_start(w, (el == 2 || el == 9));
            if (get_done(w)) seen = 1'b1;
            else if (chk_vec) check("vec_step", get_vec(w), el / (s + 2));
        end
        set_start(w, 1'b0);

        got = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", el, got.lat);
            check("sig_final", get_sig(w), 32'(got.sig));
            check("vec_final", get_vec(w), 7);
            @(negedge clk);
            check("pass", get_pass(w), 32'(got.pass));
            check("done_single", 32'(get_done(w)), 0);
            set_exp(w, ~exp_in);
            dones = 0;
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (get_done(w)) dones++;
            end
            check("extra_done", dones, 0);
            check("busy_idle", get_busy(w), 0);
            check("pass_hold", get_pass(w), 32'(got.pass));
            check("sig_hold", get_sig(w), 32'(got.sig));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e, got;
        int unsigned t0, t1, at, dones;
        bit          ok;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        exp0   = '0;
        exp3   = '0;
        repeat (3) @(negedge clk);
        check("rst_vec", 32'(vec0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_sig", 32'(sig0), 32'(SEED_V));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(0, 0, 16'h0000, 1'b1, 1'b0);
        check("sig_zero_const", 32'(sig0), 32'h0000);
        sweep(0, 1, 16'h0080, 1'b0, 1'b0);
        check("sig_v0_const", 32'(sig0), 32'h0080);
        sweep(0, 1, 16'h0081, 1'b0, 1'b0);
        sweep(0, 2, 16'h0001, 1'b0, 1'b1);
        check("sig_v7_const", 32'(sig0), 32'h0001);
        sweep(1, 2, 16'h0001, 1'b1, 1'b0);
        check("sig_v7_settle3", 32'(sig3), 32'h0001);

        // Back-to-back sweeps with start held high.
        e.sig  = model_sig(3);
        e.pass = 1'b1;
        e.lat  = 16;
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        mode0  = 3;
        exp0   = model_sig(3);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        wait_done0(at, ok);
        got = sb.pop_front();
        if (ok) begin
            check("b2b_lat1", at - t0, got.lat);
            check("b2b_sig1", 32'(sig0), 32'(got.sig));
            @(negedge clk);
            t1 = cyc;
            check("b2b_busy", 32'(busy0), 1);
            check("b2b_vec", 32'(vec0), 0);
            check("b2b_pass1", 32'(pass0), 32'(got.pass));
            check("b2b_sig_seed", 32'(sig0), 32'(SEED_V));
            start0 = 1'b0;
            wait_done0(at, ok);
            got = sb.pop_front();
            if (ok) begin
                check("b2b_lat2", at - t1, got.lat);
                check("b2b_sig2", 32'(sig0), 32'(got.sig));
                @(negedge clk);
                check("b2b_pass2", 32'(pass0), 32'(got.pass));
            end
        end else begin
            void'(sb.pop_front());
        end
        start0 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-sweep takes effect without waiting for a clock edge.
        mode0  = 1;
        exp0   = 16'h0080;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vec", 32'(vec0), 0);
        check("arst_busy", 32'(busy0), 0);
        check("arst_done", 32'(done0), 0);
        check("arst_sig", 32'(sig0), 32'(SEED_V));
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0) dones++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done0) dones++;
        end
        check("arst_no_done", dones, 0);
        check("arst_idle", 32'(busy0), 0);
        sweep(0, 1, 16'h0080, 1'b0, 1'b0);

        // Original, balanced and faulty netlists against the original's signature.
        sweep(0, 3, model_sig(3), 1'b0, 1'b0);
        sweep(0, 4, model_sig(3), 1'b0, 1'b0);
        check("balanced_pass", 32'(pass0), 1);
        sweep(0, 5, model_sig(3), 1'b0, 1'b0);
        check("faulty_pass", 32'(pass0), 0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/exhaustive_vector_sequencer.md
Name: exhaustive_vector_sequencer

Overview:
- Controller that exhaustively sequences a combinational benchmark netlist (N_IN inputs, N_OUT outputs, as produced by the AIG flow).
- Drives every input vector 0 .. 2^N_IN-1 onto the netlist inputs and waits a programmable settle time before sampling the outputs.
- Compacts all sampled responses into a MISR signature and compares it with an expected signature.
- Sits between a test host (start/done handshake) and one instantiated netlist under test; used for on-chip equivalence checks of original versus balanced netlist variants.

Parameters:
- N_IN, 3, number of netlist inputs (1..16).
- N_OUT, 4, number of netlist outputs (1..SIG_W).
- SIG_W, 16, MISR/signature width.
- SETTLE, 0, extra wait cycles between applying a vector and sampling (0..255).
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits.
- SEED, 16'h0000, MISR value loaded on start.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level sampled in IDLE; launches one sweep.
- expected_sig  in  SIG_W  golden signature; sampled in the DONE cycle.
- vec_out  out  N_IN  vector driven to netlist inputs x0..x(N_IN-1), LSB = x0.
- resp_in  in  N_OUT  netlist outputs f1..fN_OUT, LSB = f1.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  single-cycle pulse at the end of a sweep.
- pass  out  1  sig == expected_sig; updated in DONE, held until the next start.
- sig  out  SIG_W  current MISR value; final value held after DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, vec_out=0, busy=0, done=0, pass=0, sig=SEED, settle counter=0. Reset asserted mid-sweep aborts the sweep immediately with the same values; no done pulse is produced.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: on start=1, load vec_out=0, sig=SEED, cnt=SETTLE, clear pass, go to WAIT. Otherwise hold all values.
- WAIT: vec_out is stable. If cnt==0, go to SAMPLE; else cnt <= cnt-1. WAIT therefore lasts SETTLE+1 cycles.
- SAMPLE: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
  - If vec_out == all-ones: go to DONE and hold vec_out.
  - Else: vec_out <= vec_out+1, cnt <= SETTLE, go to WAIT.
- DONE: done=1 for this cycle only; pass <= (sig == expected_sig), using the sig value after the final SAMPLE; then go to IDLE.
- Latency: done is high in the cycle following edge number 2^N_IN*(SETTLE+2), counted from the edge that accepted start (edge 0). With the defaults, done is high after edge 16.
- start while busy: ignored; it is not queued.
- start held high continuously: a new sweep begins in the cycle after DONE (back-to-back sweeps).
- vec_out is registered and changes only on a SAMPLE-to-WAIT transition or a start load, so it is glitch-free toward the netlist.
- Vector counter wrap is never used: the all-ones vector terminates the sweep.
- expected_sig may change at any time; only its DONE-cycle value matters.

Decomposition:
- Shared package evs_pkg holds:
  - the state enum (IDLE, WAIT, SAMPLE, DONE);
  - default POLY/SEED constants;
  - function misr_step(sig, resp, poly), the single source of truth shared by RTL and the bench model.
- One sub-module, misr_reg: SIG_W register with load-seed and step enables, async active-low reset. The FSM, vector counter and settle counter stay in the top module.

Test Plan:
- Defaults, resp_in tied to 0, expected_sig=0x0000, pulse start → vec_out steps 0..7 every 2 cycles, done after edge 16, sig=0x0000, pass=1.
- Defaults, resp_in=1 only while vec_out==0 → final sig=0x0080; expected_sig=0x0080 gives pass=1; expected_sig=0x0081 gives pass=0.
- Defaults, resp_in=1 only while vec_out==7 → sig=0x0001; SETTLE=3 same stimulus → identical sig, done after edge 40, each vector held 4 cycles in WAIT.
- Drive start pulses during busy at cycles 3 and 10 → ignored, exactly one done pulse; start held high → second sweep begins in the cycle after done, busy stays high across the boundary.
- Assert rst_n=0 at cycle 7 mid-sweep → vec_out=0, busy=0, sig=SEED immediately (asynchronously); no done pulse; a subsequent start completes a normal sweep.
- Connect the real CCGRCG26 netlist and its balanced variant in turn, each with the model-computed expected_sig → pass=1 for both; flip one output bit via forced inversion → pass=0.
